// File: rtl/key_pkg.sv
// Shared types and widths for the keypad front end.
//   key_state_t : scan controller FSM states
//   KEY_W       : number of raw key lines
//   CODE_W      : width of the BCD key index
package key_pkg;

    localparam int KEY_W  = 10;
    localparam int CODE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE,
        REPEAT
    } key_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_encoder.sv
// 10-line priority encoder for active-low keys.
//   S_n : key lines, active-low, S_n[9] has the highest priority
//   L   : index of the highest-priority pressed key (0 when none)
//   GS  : 1 when at least one key is pressed
module key_encoder
    import key_pkg::*;
(
    input  logic [KEY_W-1:0]  S_n,
    output logic [CODE_W-1:0] L,
    output logic              GS
);

    // Ascending scan so the highest pressed index is the last one written.
    always_comb begin
        L  = '0;
        GS = 1'b0;
        for (int i = 0; i < KEY_W; i++) begin
            if (!S_n[i]) begin
                L  = CODE_W'(i);
                GS = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_scan_ctrl.sv
// Keypad scan controller: synchronises and debounces the raw keys, emits one
// event per accepted press plus auto-repeat events, and holds each event in a
// 1-deep valid/ready register for the consumer.
//   clk, rst   : clock, synchronous active-high reset
//   S_n        : raw active-low keys (asynchronous)
//   key_ready  : consumer pops the pending event
//   ovf_clr    : clears the sticky drop flag
//   key_code   : key index of the pending event
//   key_valid  : event pending
//   key_rpt    : pending event is a repeat
//   key_held   : a key is accepted and currently held
//   key_ovf    : sticky, an event was dropped because the register was full
module key_scan_ctrl
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYC  = 4,
    parameter int unsigned HOLD_CYC = 16,
    parameter int unsigned REP_CYC  = 8,
    parameter bit          REP_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  S_n,
    input  logic              key_ready,
    input  logic              ovf_clr,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_rpt,
    output logic              key_held,
    output logic              key_ovf
);

    localparam int unsigned MAXC  = max3(DEB_CYC, HOLD_CYC, REP_CYC);
    localparam int          CNT_W = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    logic [KEY_W-1:0]  sync1_q, sync1_d;
    logic [KEY_W-1:0]  sync2_q, sync2_d;
    key_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [CODE_W-1:0] cand_q,  cand_d;
    logic [CODE_W-1:0] code_q,  code_d;
    logic              valid_q, valid_d;
    logic              rpt_q,   rpt_d;
    logic              ovf_q,   ovf_d;

    logic [CODE_W-1:0] enc_code;
    logic              enc_gs;
    logic              same;
    logic              emit;
    logic              emit_rpt;

    key_encoder u_enc (
        .S_n (sync2_q),
        .L   (enc_code),
        .GS  (enc_gs)
    );

    // The accepted key is still the one being pressed.
    assign same = enc_gs && (enc_code == cand_q);

    always_comb begin
        sync1_d  = S_n;
        sync2_d  = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        cand_d   = cand_q;
        emit     = 1'b0;
        emit_rpt = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enc_gs) begin
                    state_d = DEBOUNCE;
                    cand_d  = enc_code;
                end
            end
            DEBOUNCE: begin
                if (!enc_gs) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (enc_code != cand_q) begin
                    cand_d = enc_code;
                    cnt_d  = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    emit    = 1'b1;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (!same) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (!REP_EN) begin
                    // No repeat pending: park the counter instead of letting it wrap.
                    cnt_d = cnt_q;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d  = REPEAT;
                    emit     = 1'b1;
                    emit_rpt = 1'b1;
                    cnt_d    = '0;
                end
            end
            REPEAT: begin
                if (!same) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    emit     = 1'b1;
                    emit_rpt = 1'b1;
                    cnt_d    = '0;
                end
            end
            RELEASE: begin
                if (enc_gs) begin
                    // Returning to the same key is a bounce; any other key
                    // just restarts the all-released window.
                    cnt_d = '0;
                    if (enc_code == cand_q) state_d = PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output holding register. A drop and a clear in the same cycle leave
    // the flag set.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        rpt_d   = rpt_q;
        ovf_d   = ovf_q & ~ovf_clr;
        if (emit) begin
            if (!valid_q || key_ready) begin
                valid_d = 1'b1;
                code_d  = cand_q;
                rpt_d   = emit_rpt;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && key_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            rpt_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            rpt_q   <= rpt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_rpt   = rpt_q;
    assign key_ovf   = ovf_q;
    assign key_held  = (state_q == PRESSED) || (state_q == REPEAT);

endmodule
